// File: rtl/ahb_seg_key_ctrl_if.sv
// rtl/ahb_seg_key_ctrl_if.sv - AHB-Lite slave bus bundle for the segment/key controller
interface ahb_seg_key_ctrl_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport slave (
    input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HREADYOUT, HRDATA, HRESP
  );

  modport master (
    output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_seg_key_ctrl.sv
// rtl/ahb_seg_key_ctrl.sv - AHB-Lite multiplexed seven-segment display and key-event FIFO
module ahb_seg_key_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_seg_key_ctrl_if.slave     bus,
  input  logic [4:0]            key_code,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic                  key_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_CTRL = 3'd1;
  localparam logic [2:0] A_STAT = 3'd2;
  localparam logic [2:0] A_FIFO = 3'd3;
  localparam logic [2:0] A_IRQ  = 3'd4;

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.HSIZE, bus.HADDR[31:5], bus.HADDR[1:0], bus.HTRANS[0], bus.HWDATA};

  logic       dp_valid;
  logic       dp_write;
  logic [2:0] dp_addr;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 3'd0;
    end else if (bus.HREADY) begin
      dp_valid <= bus.HSEL & bus.HTRANS[1];
      dp_write <= bus.HWRITE;
      dp_addr  <= bus.HADDR[4:2];
    end
  end

  logic [4*NUM_DIGITS-1:0] disp_data;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    disp_en;
  logic                    irq_en;
  logic                    overflow;

  logic [4:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic [4:0]    key_prev;

  logic wr_en, rd_en, pop, push, key_evt, fifo_empty, fifo_full, ovf_clr;

  assign wr_en      = dp_valid & dp_write & bus.HREADY;
  assign rd_en      = dp_valid & ~dp_write;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign pop        = rd_en & bus.HREADY & (dp_addr == A_FIFO) & ~fifo_empty;
  assign key_evt    = (key_code != 5'd0) && (key_prev == 5'd0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
  assign push       = key_evt & (~fifo_full | pop);
  assign ovf_clr    = wr_en & (dp_addr == A_IRQ) & bus.HWDATA[1];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      disp_data  <= '0;
      blank_mask <= '0;
      dp_mask    <= '0;
      disp_en    <= 1'b0;
      irq_en     <= 1'b0;
    end else if (wr_en) begin
      case (dp_addr)
        A_DATA: disp_data <= bus.HWDATA[4*NUM_DIGITS-1:0];
        A_CTRL: begin
          blank_mask <= bus.HWDATA[NUM_DIGITS-1:0];
          dp_mask    <= bus.HWDATA[8 +: NUM_DIGITS];
          disp_en    <= bus.HWDATA[16];
        end
        A_IRQ:  irq_en <= bus.HWDATA[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= key_code;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
      key_prev <= 5'd0;
    end else begin
      key_prev <= key_code;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
      if (key_evt & fifo_full & ~pop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    case (dp_addr)
      A_DATA: rd_word[4*NUM_DIGITS-1:0] = disp_data;
      A_CTRL: begin
        rd_word[NUM_DIGITS-1:0]   = blank_mask;
        rd_word[8 +: NUM_DIGITS]  = dp_mask;
        rd_word[16]               = disp_en;
      end
      A_STAT: begin
        rd_word[0]        = fifo_empty;
        rd_word[1]        = fifo_full;
        rd_word[2]        = overflow;
        rd_word[8 +: AW+1] = fifo_cnt;
      end
      A_FIFO: if (!fifo_empty) rd_word = {1'b1, 26'd0, fifo_mem[rd_ptr]};
      A_IRQ:  rd_word[0] = irq_en;
      default: ;
    endcase
  end

  assign bus.HRDATA = rd_en ? rd_word : 32'd0;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  logic [CW-1:0] scan_cnt;
  logic [IW-1:0] dig_idx;
  logic [3:0]    cur_nib;

  assign cur_nib = disp_data[{dig_idx, 2'b00} +: 4];

  // Pins are driven from the registered index, so they trail an index change by one cycle.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
      seg      <= 7'h7F;
      an       <= '1;
      dp       <= 1'b1;
      key_irq  <= 1'b0;
    end else begin
      if (scan_cnt == CW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        dig_idx  <= (dig_idx == IW'(NUM_DIGITS - 1)) ? '0 : dig_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      seg     <= hex_seg(cur_nib);
      an      <= (disp_en && !blank_mask[dig_idx]) ? ~(NUM_DIGITS'(1) << dig_idx) : '1;
      dp      <= ~dp_mask[dig_idx];
      key_irq <= irq_en & (~fifo_empty | overflow);
    end
  end

endmodule

// File: tb/tb_ahb_seg_key_ctrl.sv
// tb/tb_ahb_seg_key_ctrl.sv - directed scoreboard bench for ahb_seg_key_ctrl
module tb_ahb_seg_key_ctrl;
  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [4:0] key_code;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       key_irq;

  ahb_seg_key_ctrl_if bus();

  ahb_seg_key_ctrl #(.NUM_DIGITS(4), .FIFO_DEPTH(8), .SCAN_DIV(4)) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .bus     (bus),
    .key_code(key_code),
    .seg     (seg),
    .an      (an),
    .dp      (dp),
    .key_irq (key_irq)
  );

  always #5 HCLK = ~HCLK;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q [$];

  logic [3:0] scan_an  [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b0111};
  logic [3:0] scan_nib [4] = '{4'h1, 4'h7, 4'hA, 4'h3};
  logic       scan_dp  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h1: glyph = 7'b1111001;
      4'h3: glyph = 7'b0110000;
      4'h7: glyph = 7'b1111000;
      4'hA: glyph = 7'b0001000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'd0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = addr;
    @(posedge HCLK); #1;
    idle();
    bus.HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = addr;
    @(posedge HCLK); #1;
    idle();
    chk(tag, bus.HRDATA, exp_q.pop_front());
    @(posedge HCLK); #1;
  endtask

  task automatic key_step(input logic [4:0] c, input int n);
    key_code = c;
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic press(input logic [4:0] c);
    key_step(c, 2);
    key_step(5'd0, 2);
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.HREADY = 1'b1;
    bus.HSIZE  = 3'b010;
    bus.HWDATA = 32'd0;
    key_code   = 5'd0;
    do_reset();

    // Reset state and register defaults
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'h1);
    chk("rst_irq", {31'd0, key_irq}, 32'h0);
    chk("rst_hrdata_idle", bus.HRDATA, 32'h0);
    bus_read(32'h00, 32'h0, "rst_disp_data");
    bus_read(32'h04, 32'h0, "rst_disp_ctrl");
    bus_read(32'h08, 32'h1, "rst_key_stat");
    bus_read(32'h0C, 32'h0, "rst_key_fifo");
    bus_read(32'h10, 32'h0, "rst_irq_ctrl");
    bus_read(32'h14, 32'h0, "unmapped_14");
    bus_read(32'h1C, 32'h0, "unmapped_1c");
    bus_write(32'h08, 32'hFFFF_FFFF);
    bus_read(32'h08, 32'h1, "ro_stat_write_ignored");

    // Display scan
    bus_write(32'h00, 32'h1234_3A71);
    bus_read(32'h00, 32'h0000_3A71, "disp_data_trunc");
    bus_write(32'h04, 32'h0001_0204);
    bus_read(32'h04, 32'h0001_0204, "disp_ctrl_rb");
    for (int i = 0; i < 64 && an !== 4'b0111; i++) begin
      @(posedge HCLK); #1;
    end
    chk("scan_sync_d3", {28'd0, an}, 32'h7);
    for (int i = 0; i < 64 && an !== 4'b1110; i++) begin
      @(posedge HCLK); #1;
    end
    chk("scan_sync_d0", {28'd0, an}, 32'hE);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({20'd0, scan_an[i/4], glyph(scan_nib[i/4]), scan_dp[i/4]});
    end
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("scan_cyc%0d", i), {20'd0, an, seg, dp}, exp_q.pop_front());
      @(posedge HCLK); #1;
    end
    bus_write(32'h04, 32'hFFFF_FFFF);
    bus_read(32'h04, 32'h0001_0F0F, "disp_ctrl_mask");
    bus_write(32'h04, 32'h0);
    @(posedge HCLK); #1;
    chk("disabled_an", {28'd0, an}, 32'hF);

    // Key capture: hold, release, direct code change
    key_step(5'h05, 10);
    key_step(5'h00, 2);
    key_step(5'h13, 3);
    key_step(5'h1F, 3);
    key_step(5'h00, 2);
    bus_read(32'h08, 32'h0000_0200, "stat_two");
    bus_read(32'h0C, 32'h8000_0005, "fifo_pop_05");
    bus_read(32'h0C, 32'h8000_0013, "fifo_pop_13");
    bus_read(32'h0C, 32'h0, "fifo_pop_empty");
    bus_read(32'h08, 32'h1, "stat_empty_again");

    // Interrupt
    bus_write(32'h10, 32'h1);
    bus_read(32'h10, 32'h1, "irq_ctrl_rb");
    key_step(5'h07, 1);
    key_step(5'h00, 1);
    chk("irq_on_press", {31'd0, key_irq}, 32'h1);
    bus_read(32'h0C, 32'h8000_0007, "fifo_pop_07");
    @(posedge HCLK); #1;
    chk("irq_off_after_pop", {31'd0, key_irq}, 32'h0);
    bus_write(32'h10, 32'h0);

    // Overflow
    for (int i = 1; i <= 9; i++) press(5'(i));
    bus_read(32'h08, 32'h0000_0806, "stat_overflow");
    chk("irq_masked", {31'd0, key_irq}, 32'h0);
    bus_write(32'h10, 32'h3);
    bus_read(32'h08, 32'h0000_0802, "stat_ovf_cleared");
    bus_read(32'h10, 32'h1, "irq_ctrl_bit1_ro0");
    chk("irq_full", {31'd0, key_irq}, 32'h1);
    for (int i = 1; i <= 8; i++) bus_read(32'h0C, 32'h8000_0000 | i, $sformatf("drain_%0d", i));
    bus_read(32'h08, 32'h1, "stat_drained");
    chk("irq_drained", {31'd0, key_irq}, 32'h0);
    bus_write(32'h10, 32'h0);

    // Push coinciding with pop while full
    for (int i = 17; i <= 24; i++) press(5'(i));
    bus_read(32'h08, 32'h0000_0802, "stat_full_again");
    exp_q.push_back(32'h8000_0011);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = 32'h0C;
    @(posedge HCLK); #1;
    idle();
    key_code = 5'h19;
    chk("coincide_pop", bus.HRDATA, exp_q.pop_front());
    @(posedge HCLK); #1;
    key_code = 5'h00;
    @(posedge HCLK); #1;
    bus_read(32'h08, 32'h0000_0802, "stat_after_coincide");
    for (int i = 18; i <= 25; i++) bus_read(32'h0C, 32'h8000_0000 | i, $sformatf("drain2_%0d", i));
    bus_read(32'h08, 32'h1, "stat_drained2");

    // Reset during a pending write data phase
    press(5'h03);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 32'h00;
    @(posedge HCLK); #1;
    idle();
    bus.HWDATA = 32'h0000_ABCD;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    bus_read(32'h00, 32'h0, "rst_cancels_write");
    bus_read(32'h08, 32'h1, "rst_discards_fifo");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
